// File: rtl/mc_pkg.sv
// mc_pkg: shared types and encodings for the multicycle MIPS controller.
// Holds the FSM state enum, opcode/funct constants, ALU operation codes and
// the PCSource/ALUSrcB mux encodings, plus the ALU decode helpers.
package mc_pkg;

    typedef enum logic [3:0] {
        S_PREFETCH,
        S_FETCH,
        S_DECODE,
        S_MEMADDR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_RWB,
        S_RWB_NOP,   // write-back slot of an R-type with unknown Funct
        S_BRANCH,
        S_JUMP,
        S_IEXEC,
        S_IWB,
        S_INTR,
        S_ILLEGAL
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Funct codes (IR[5:0]) for R-type
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation codes (zero-extended to ALUCTL_W at the port)
    localparam logic [2:0] ALU_AND = 3'd0;
    localparam logic [2:0] ALU_XOR = 3'd1;
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd3;
    localparam logic [2:0] ALU_OR  = 3'd4;
    localparam logic [2:0] ALU_SLT = 3'd5;

    // PCSource encodings
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_VECTOR = 2'b11;

    // ALUSrcB encodings
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_SHIMM = 2'b11;

    // True when the Funct field names one of the supported R-type operations.
    function automatic logic funct_known(input logic [5:0] funct);
        case (funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_SLT: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

    // R-type ALU operation; unknown Funct falls back to ADD.
    function automatic logic [2:0] funct_alu(input logic [5:0] funct);
        case (funct)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_XOR:  return ALU_XOR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    // Immediate-type ALU operation selected by the opcode.
    function automatic logic [2:0] op_alu(input logic [5:0] op);
        case (op)
            OP_ANDI: return ALU_AND;
            OP_ORI:  return ALU_OR;
            OP_XORI: return ALU_XOR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_irq_arbiter.sv
// mc_irq_arbiter: rising-edge detection, pending bits, fixed-priority select
// (NMI first, then IRQ[0] highest) and one-cycle acknowledge generation.
// The vector chosen when the controller leaves PREFETCH is held so that the
// INTR cycle acknowledges exactly the source it is servicing.
module mc_irq_arbiter
    import mc_pkg::*;
#(
    parameter int N_IRQ = 4,
    parameter int VEC_W = $clog2(N_IRQ + 2)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [N_IRQ-1:0] IRQ,
    input  logic             NMI,
    input  logic             INTD,
    input  logic             grant,     // controller takes the interrupt now
    input  logic             ack_en,    // controller is in INTR
    output logic             req,
    output logic [VEC_W-1:0] vec,
    output logic [N_IRQ-1:0] irq_ack,
    output logic             nmi_ack
);

    logic [N_IRQ-1:0] irq_prev;
    logic [N_IRQ-1:0] pend;
    logic             nmi_prev;
    logic             nmi_pend;
    logic [VEC_W-1:0] sel;
    logic [VEC_W-1:0] vec_q;

    // Priority select: NMI, then the lowest-numbered pending IRQ.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        sel = '0;
        if (nmi_pend) begin
            sel = VEC_W'(N_IRQ);
        end else begin
            for (int i = N_IRQ - 1; i >= 0; i--) begin
                if (pend[i]) sel = VEC_W'(i);
            end
        end
    end

    assign req = nmi_pend | (~INTD & (|pend));
    assign vec = vec_q;

    // One-hot acknowledge of the held vector during the INTR cycle.
    always_comb begin
        irq_ack = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            irq_ack[i] = ack_en && (vec_q == VEC_W'(i));
        end
        nmi_ack = ack_en && (vec_q == VEC_W'(N_IRQ));
    end

    // Edge history, pending bits (new edge beats a coincident ack) and held vector.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (Reset) begin
            irq_prev <= '0;
            pend     <= '0;
            nmi_prev <= 1'b0;
            nmi_pend <= 1'b0;
            vec_q    <= '0;
        end else begin
            irq_prev <= IRQ;
            nmi_prev <= NMI;
            pend     <= (pend & ~irq_ack) | (IRQ & ~irq_prev);
            nmi_pend <= (nmi_pend & ~nmi_ack) | (NMI & ~nmi_prev);
            if (grant) vec_q <= sel;
        end
    end

endmodule

// File: rtl/mc_controller_irq.sv
// mc_controller_irq: multicycle MIPS control FSM with vectored interrupts.
// Drives datapath enables, mux selects and ALU control per state; services
// NMI and N_IRQ maskable lines between instructions via a one-cycle INTR state.
// Optional build macro MC_TRAP_ILLEGAL_EN: illegal opcodes and unknown R-type
// Funct codes trap through vector N_IRQ+1; without it ILLEGAL is a no-op cycle.
module mc_controller_irq
    import mc_pkg::*;
#(
    parameter  int N_IRQ    = 4,
    parameter  int ALUCTL_W = 3,
    localparam int VEC_W    = $clog2(N_IRQ + 2)
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [5:0]          Op,
    input  logic [5:0]          Funct,
    input  logic                Zero,
    input  logic [N_IRQ-1:0]    IRQ,
    input  logic                NMI,
    input  logic                INTD,
    output logic                PCWrite,
    output logic                IorD,
    output logic                MemWrite,
    output logic                MemtoReg,
    output logic                IRWrite,
    output logic                RegWrite,
    output logic                RegDst,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          PCSource,
    output logic [ALUCTL_W-1:0] ALUControl,
    output logic                EPCWrite,
    output logic [VEC_W-1:0]    IntVector,
    output logic                IsInterrupted,
    output logic [N_IRQ-1:0]    IntAck,
    output logic                NmiAck
);

    state_t           state;
    state_t           next_state;
    logic             irq_req;
    logic [VEC_W-1:0] irq_vec;
    logic [2:0]       alu_op;

    mc_irq_arbiter #(
        .N_IRQ (N_IRQ),
        .VEC_W (VEC_W)
    ) u_arbiter (
        .Clk     (Clk),
        .Reset   (Reset),
        .IRQ     (IRQ),
        .NMI     (NMI),
        .INTD    (INTD),
        .grant   ((state == S_PREFETCH) && irq_req),
        .ack_en  (state == S_INTR),
        .req     (irq_req),
        .vec     (irq_vec),
        .irq_ack (IntAck),
        .nmi_ack (NmiAck)
    );

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge Clk) begin
        if (Reset) state <= S_PREFETCH;
        else       state <= next_state;
    end

    // Next-state decode.
    always_comb begin
        next_state = S_PREFETCH;
        unique case (state)
            S_PREFETCH: next_state = irq_req ? S_INTR : S_FETCH;
            S_FETCH:    next_state = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW:                      next_state = S_MEMADDR;
                    OP_RTYPE:                          next_state = S_EXEC;
                    OP_BEQ:                            next_state = S_BRANCH;
                    OP_J:                              next_state = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: next_state = S_IEXEC;
                    default:                           next_state = S_ILLEGAL;
                endcase
            end
            S_MEMADDR:  next_state = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:    next_state = S_MEMWB;
            S_EXEC: begin
`ifdef MC_TRAP_ILLEGAL_EN
                next_state = funct_known(Funct) ? S_RWB : S_ILLEGAL;
`else
                next_state = funct_known(Funct) ? S_RWB : S_RWB_NOP;
`endif
            end
            S_IEXEC:    next_state = S_IWB;
            S_INTR:     next_state = S_FETCH;
            S_ILLEGAL: begin
`ifdef MC_TRAP_ILLEGAL_EN
                next_state = S_FETCH;
`else
                next_state = S_PREFETCH;
`endif
            end
            default:    next_state = S_PREFETCH;  // MEMWB, MEMWR, RWB(_NOP), BRANCH, JUMP, IWB
        endcase
    end

    // Per-state datapath controls; all default to 0.
    always_comb begin
        PCWrite       = 1'b0;
        IorD          = 1'b0;
        MemWrite      = 1'b0;
        MemtoReg      = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        RegDst        = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = SRCB_REG;
        PCSource      = PCSRC_ALU;
        alu_op        = ALU_AND;
        EPCWrite      = 1'b0;
        IntVector     = '0;
        IsInterrupted = 1'b0;
        unique case (state)
            S_FETCH: begin
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                ALUSrcB = SRCB_FOUR;
                alu_op  = ALU_ADD;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_SHIMM;
                alu_op  = ALU_ADD;
            end
            S_MEMADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALU_ADD;
            end
            S_MEMRD: IorD = 1'b1;
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                alu_op  = funct_alu(Funct);
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_RWB_NOP: RegDst = 1'b1;
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                alu_op   = ALU_SUB;
                PCSource = PCSRC_ALUOUT;
                PCWrite  = Zero;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            S_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                alu_op  = op_alu(Op);
            end
            S_IWB: RegWrite = 1'b1;
            S_INTR: begin
                IsInterrupted = 1'b1;
                EPCWrite      = 1'b1;
                PCWrite       = 1'b1;
                PCSource      = PCSRC_VECTOR;
                IntVector     = irq_vec;
            end
            S_ILLEGAL: begin
`ifdef MC_TRAP_ILLEGAL_EN
                IsInterrupted = 1'b1;
                EPCWrite      = 1'b1;
                PCWrite       = 1'b1;
                PCSource      = PCSRC_VECTOR;
                IntVector     = VEC_W'(N_IRQ + 1);
`endif
            end
            default: ;  // PREFETCH: everything stays 0
        endcase
    end

    assign ALUControl = ALUCTL_W'(alu_op);

endmodule

// File: tb/tb_mc_controller_irq.sv
// tb_mc_controller_irq: directed bench for mc_controller_irq (default
// parameters). An instruction-level model expands each directed instruction
// into its expected per-cycle control vectors, including interrupt entry
// chosen from a model of the pending bits; one process compares the DUT to
// the expected vector every cycle. Literal checks pin vectors, acks, ALU
// codes and instruction lengths. Honours MC_TRAP_ILLEGAL_EN like the RTL.
module tb_mc_controller_irq;

    typedef struct packed {
        logic       pcw, iord, memw, m2r, irw, regw, regdst, srca;
        logic [1:0] srcb;
        logic [1:0] pcsrc;
        logic [2:0] alu;
        logic       epcw;
        logic [2:0] vec;
        logic       isint;
        logic [3:0] ack;
        logic       nmiack;
    } outv_t;

    logic       Clk = 1'b0;
    logic       Reset, Zero, NMI, INTD;
    logic [5:0] Op, Funct;
    logic [3:0] IRQ;

    logic       PCWrite, IorD, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUControl;
    logic       EPCWrite;
    logic [2:0] IntVector;
    logic       IsInterrupted;
    logic [3:0] IntAck;
    logic       NmiAck;

    mc_controller_irq dut (
        .Clk(Clk), .Reset(Reset), .Op(Op), .Funct(Funct), .Zero(Zero),
        .IRQ(IRQ), .NMI(NMI), .INTD(INTD),
        .PCWrite(PCWrite), .IorD(IorD), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUControl(ALUControl),
        .EPCWrite(EPCWrite), .IntVector(IntVector), .IsInterrupted(IsInterrupted),
        .IntAck(IntAck), .NmiAck(NmiAck)
    );

    always #5 Clk = ~Clk;

    outv_t dut_v;
    assign dut_v = {PCWrite, IorD, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA,
                    ALUSrcB, PCSource, ALUControl, EPCWrite, IntVector, IsInterrupted,
                    IntAck, NmiAck};

    int    n_vec = 0;
    int    n_bad = 0;
    outv_t exp_cur = '0;
    logic  exp_valid = 1'b0;
    string tag = "";

    // observations of the DUT used by the literal checks
    int   cyc = 0, last_fetch = 0, fetch_gap = 0;
    int   obs_vec = -1, obs_ack = -1, obs_nmi = -1, obs_alu = -1;

    // model of the interrupt pending state
    logic [3:0] m_pend = '0, m_prev = '0;
    logic       m_nmi = 1'b0, m_nprev = 1'b0;
    logic       skip_pf = 1'b0;

    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Per-cycle comparison, half a cycle after the active edge.
    always @(negedge Clk) begin
        if (exp_valid) begin
            n_vec++;
            if (dut_v !== exp_cur) begin
                n_bad++;
                $display("FAIL cycle %0d [%s]: got %h, expected %h", cyc, tag, dut_v, exp_cur);
            end
        end
        if (IsInterrupted) begin
            obs_vec = int'(IntVector);
            obs_ack = int'(IntAck);
            obs_nmi = int'(NmiAck);
        end
        if (IRWrite) begin
            fetch_gap  = cyc - last_fetch;
            last_fetch = cyc;
        end
        if (ALUSrcA && ALUSrcB == 2'b00 && PCSource == 2'b00) obs_alu = int'(ALUControl);
        cyc++;
    end

    // Pending-bit model: edges set, the ack of the ending cycle clears, edge wins.
    always @(posedge Clk) begin
        if (Reset) begin
            m_pend = '0; m_prev = '0; m_nmi = 1'b0; m_nprev = 1'b0;
        end else begin
            m_pend  = (m_pend & ~(exp_valid ? exp_cur.ack : 4'b0)) | (IRQ & ~m_prev);
            m_nmi   = (m_nmi & ~(exp_valid & exp_cur.nmiack)) | (NMI & ~m_nprev);
            m_prev  = IRQ;
            m_nprev = NMI;
        end
    end

    task automatic step(input outv_t e, input string t);
        exp_cur   = e;
        exp_valid = 1'b1;
        tag       = t;
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [2:0] m_funct_alu(input logic [5:0] f);
        case (f)
            6'b100010: return 3'd3;
            6'b100100: return 3'd0;
            6'b100101: return 3'd4;
            6'b100110: return 3'd1;
            6'b101010: return 3'd5;
            default:   return 3'd2;
        endcase
    endfunction

    function automatic logic m_funct_ok(input logic [5:0] f);
        return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b101010};
    endfunction

    function automatic outv_t trap_rec();
        outv_t r = '0;
`ifdef MC_TRAP_ILLEGAL_EN
        r.isint = 1; r.epcw = 1; r.pcw = 1; r.pcsrc = 2'b11; r.vec = 3'd5;
`endif
        return r;
    endfunction

    // Run one instruction from PREFETCH (or FETCH after a trap) to its end.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                             input int abort_at = -1, input logic [3:0] irq_on_intr = 4'b0);
        outv_t q[$];
        outv_t r;
        int    v;
        Op = op; Funct = fn; Zero = zero;
        if (!skip_pf) begin
            v = -1;
            if (m_nmi) v = 4;
            else if (!INTD) for (int i = 3; i >= 0; i--) if (m_pend[i]) v = i;
            step('0, "prefetch");
            if (v >= 0) begin
                r = '0; r.isint = 1; r.epcw = 1; r.pcw = 1; r.pcsrc = 2'b11; r.vec = 3'(v);
                if (v == 4) r.nmiack = 1; else r.ack = 4'(1 << v);
                IRQ = IRQ | irq_on_intr;
                step(r, "intr");
            end
        end
        skip_pf = 1'b0;
        r = '0; r.irw = 1; r.pcw = 1; r.srcb = 2'b01; r.alu = 3'd2; q.push_back(r);
        r = '0; r.srcb = 2'b11; r.alu = 3'd2; q.push_back(r);
        case (op)
            6'b100011, 6'b101011: begin
                r = '0; r.srca = 1; r.srcb = 2'b10; r.alu = 3'd2; q.push_back(r);
                if (op == 6'b100011) begin
                    r = '0; r.iord = 1; q.push_back(r);
                    r = '0; r.regw = 1; r.m2r = 1; q.push_back(r);
                end else begin
                    r = '0; r.iord = 1; r.memw = 1; q.push_back(r);
                end
            end
            6'b000000: begin
                r = '0; r.srca = 1; r.alu = m_funct_alu(fn); q.push_back(r);
                if (m_funct_ok(fn)) begin
                    r = '0; r.regw = 1; r.regdst = 1; q.push_back(r);
                end else begin
`ifdef MC_TRAP_ILLEGAL_EN
                    q.push_back(trap_rec()); skip_pf = 1'b1;
`else
                    r = '0; r.regdst = 1; q.push_back(r);
`endif
                end
            end
            6'b000100: begin
                r = '0; r.srca = 1; r.alu = 3'd3; r.pcsrc = 2'b01; r.pcw = zero; q.push_back(r);
            end
            6'b000010: begin
                r = '0; r.pcw = 1; r.pcsrc = 2'b10; q.push_back(r);
            end
            6'b001000, 6'b001100, 6'b001101, 6'b001110: begin
                r = '0; r.srca = 1; r.srcb = 2'b10;
                r.alu = (op == 6'b001100) ? 3'd0 : (op == 6'b001101) ? 3'd4 :
                        (op == 6'b001110) ? 3'd1 : 3'd2;
                q.push_back(r);
                r = '0; r.regw = 1; q.push_back(r);
            end
            default: begin
                q.push_back(trap_rec());
`ifdef MC_TRAP_ILLEGAL_EN
                skip_pf = 1'b1;
`endif
            end
        endcase
        foreach (q[i]) begin
            if (i == abort_at) Reset = 1'b1;
            step(q[i], $sformatf("op%02h_c%0d", op, i));
            if (i == abort_at) begin
                Reset = 1'b0;
                skip_pf = 1'b0;
                return;
            end
        end
    endtask

    localparam logic [5:0] R = 6'b000000;

    initial begin
        Reset = 1'b1; Op = '0; Funct = '0; Zero = 1'b0; IRQ = '0; NMI = 1'b0; INTD = 1'b0;
        @(posedge Clk); #1;
        step('0, "reset");
        Reset = 1'b0;
        check("reset_regwrite", int'(RegWrite), 0);

        // R-type SUB, then length pins
        run_instr(R, 6'b100010, 0);
        check("sub_aluctl", obs_alu, 3);
        run_instr(6'b000010, 0, 0);
        check("rtype_len", fetch_gap, 5);
        run_instr(6'b100011, 0, 0);
        check("j_len", fetch_gap, 4);
        run_instr(6'b101011, 0, 0);
        check("lw_len", fetch_gap, 6);
        run_instr(6'b001000, 0, 0);
        check("sw_len", fetch_gap, 5);
        run_instr(6'b000100, 0, 0);
        check("addi_len", fetch_gap, 5);
        run_instr(6'b000100, 0, 1);
        check("beq_len", fetch_gap, 4);

        // remaining ALU operations
        run_instr(R, 6'b100100, 0);
        run_instr(R, 6'b100101, 0);
        run_instr(R, 6'b100110, 0);
        run_instr(R, 6'b101010, 0);
        check("slt_aluctl", obs_alu, 5);
        run_instr(6'b001100, 0, 0);
        run_instr(6'b001101, 0, 0);
        run_instr(6'b001110, 0, 0);
        run_instr(R, 6'b100111, 0);   // unknown Funct
        run_instr(6'b000010, 0, 0);

        // reset during MEMWB of lw
        run_instr(6'b100011, 0, 0, 4);
        check("abort_regwrite", int'(RegWrite), 0);
        run_instr(6'b000010, 0, 0);

        // IRQ 0110 rising during an add
        IRQ = 4'b0110;
        run_instr(R, 6'b100000, 0);
        run_instr(R, 6'b100000, 0);
        check("irq1_vec", obs_vec, 1);
        check("irq1_ack", obs_ack, 2);
        run_instr(R, 6'b100000, 0);
        check("irq2_vec", obs_vec, 2);
        check("irq2_ack", obs_ack, 4);
        run_instr(R, 6'b100000, 0);
        IRQ = 4'b0000;

        // NMI with IRQ[0] masked by INTD
        INTD = 1'b1; NMI = 1'b1; IRQ = 4'b0001;
        run_instr(R, 6'b100000, 0);
        run_instr(R, 6'b100000, 0);
        check("nmi_vec", obs_vec, 4);
        check("nmi_ack", obs_nmi, 1);
        run_instr(R, 6'b100000, 0);
        INTD = 1'b0;
        run_instr(R, 6'b100000, 0);
        check("irq0_vec", obs_vec, 0);
        check("irq0_ack", obs_ack, 1);
        NMI = 1'b0; IRQ = 4'b0000;

        // new edge coincident with the ack keeps the bit pending
        IRQ = 4'b1000;
        run_instr(R, 6'b100000, 0);
        IRQ = 4'b0000;
        run_instr(R, 6'b100000, 0, -1, 4'b1000);
        obs_vec = -1;
        run_instr(R, 6'b100000, 0);
        check("rearm_vec", obs_vec, 3);
        IRQ = 4'b0000;
        run_instr(6'b000010, 0, 0);

        // illegal opcode
        run_instr(6'b111111, 0, 0);
        run_instr(6'b000010, 0, 0);
`ifdef MC_TRAP_ILLEGAL_EN
        check("trap_vec", obs_vec, 5);
        check("trap_len", fetch_gap, 3);
`else
        check("illegal_len", fetch_gap, 4);
`endif
        run_instr(6'b000010, 0, 0);

        exp_valid = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_controller_irq.md
Name: mc_controller_irq

Overview:
- Multicycle MIPS control FSM, next generation: drives datapath enables, mux selects and ALU control per state.
- Adds N vectored maskable interrupt lines plus NMI, with fixed priority, edge-latched pending bits and per-line acknowledge.
- Adds an EPC write strobe, a conditional branch write and a wider ALU operation set.
- Sits between the instruction register (Op, Funct) and the datapath; replaces the single-INT controller.

Parameters:
- N_IRQ, 4, number of maskable interrupt lines; legal 1..8.
- ALUCTL_W, 3, width of ALUControl; legal 3..4.
- VEC_W, $clog2(N_IRQ+2), localparam, width of IntVector.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Op  in  6  IR[31:26].
- Funct  in  6  IR[5:0].
- Zero  in  1  ALU zero flag.
- IRQ  in  N_IRQ  maskable interrupt requests; bit 0 has highest priority.
- NMI  in  1  non-maskable interrupt request.
- INTD  in  1  interrupt disable; masks IRQ only.
- PCWrite, IorD, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA  out  1 each  datapath enables/selects.
- ALUSrcB  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = shifted imm.
- PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target, 11 = IntVector.
- ALUControl  out  ALUCTL_W  ALU operation.
- EPCWrite  out  1  capture PC into EPC.
- IntVector  out  VEC_W  selected vector: 0..N_IRQ-1 = IRQ index, N_IRQ = NMI, N_IRQ+1 = illegal-opcode trap.
- IsInterrupted  out  1  high while in INTR.
- IntAck  out  N_IRQ  one-hot, one-cycle acknowledge.
- NmiAck  out  1  one-cycle NMI acknowledge.

Behaviour:
- Reset:
  - Reset=1 at an edge forces state PREFETCH and clears all pending bits and edge-history registers.
  - Every output is 0 in the cycle after reset.
  - Reset mid-instruction aborts it; no further RegWrite, MemWrite or PCWrite pulse of that instruction occurs.
- Output rule: every output is driven in every state, defaulting to 0. Outputs are a pure function of state, except ALUControl (also Op/Funct) and PCWrite in BRANCH (also Zero). No latches.
- Pending bits:
  - pend[i] sets on a rising edge of IRQ[i], detected against the previous cycle's sample; NMI sets nmi_pend the same way.
  - A pending bit clears on its ack cycle.
  - A new rising edge coincident with the ack wins, so the bit stays set.
- States and transitions:
  - PREFETCH:
    - nmi_pend → INTR (NMI).
    - Otherwise, if INTD=0 and any pend → INTR (lowest set index).
    - Otherwise → FETCH.
  - FETCH: IRWrite=1, PCWrite=1, ALUSrcB=01, ALU op ADD. Next: DECODE.
  - DECODE: ALUSrcB=11, ALU op ADD.
    - lw/sw → MEMADDR.
    - R-type (000000) → EXEC.
    - beq (000100) → BRANCH.
    - j (000010) → JUMP.
    - addi (001000), andi (001100), ori (001101), xori (001110) → IEXEC.
    - Any other Op → ILLEGAL.
  - MEMADDR: ALUSrcA=1, ALUSrcB=10, ADD. Next: MEMRD for lw, MEMWR for sw.
  - MEMRD: IorD=1. Next: MEMWB.
  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next: PREFETCH.
  - MEMWR: IorD=1, MemWrite=1. Next: PREFETCH.
  - EXEC: ALUSrcA=1, ALUSrcB=00, op from Funct. Next: RWB.
  - RWB: RegWrite=1, RegDst=1. Next: PREFETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCSource=01, PCWrite=Zero. Next: PREFETCH.
  - JUMP: PCWrite=1, PCSource=10. Next: PREFETCH.
  - IEXEC: ALUSrcA=1, ALUSrcB=10, op from Op. Next: IWB.
  - IWB: RegWrite=1, RegDst=0. Next: PREFETCH.
  - INTR (1 cycle): IsInterrupted=1, EPCWrite=1, PCWrite=1, PCSource=11, IntVector and the matching ack high. Next: FETCH.
  - ILLEGAL: see Optional Feature.
- ALU selection is decoded on the state's current Op/Funct with no latency; no dependence on previous ALUOp.
- ALUControl codes: AND=0, XOR=1, ADD=2, SUB=3, OR=4, SLT=5. Upper bits are 0 when ALUCTL_W=4.
- Funct decode: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 101010 SLT.
- An unknown Funct in EXEC gives ADD with RegWrite suppressed in RWB.
- Cycle counts including PREFETCH: lw 6, sw 5, R-type 5, I-type 5, beq 4, j 4. A taken interrupt adds 1 cycle (INTR) before FETCH.

Optional Feature:
- Macro MC_TRAP_ILLEGAL_EN.
- Defined:
  - ILLEGAL behaves as INTR with IntVector=N_IRQ+1 and no ack asserted. Next: FETCH.
  - An unknown Funct in EXEC also goes to ILLEGAL instead of RWB.
- Undefined:
  - ILLEGAL is a 1-cycle no-op (all outputs 0). Next: PREFETCH.
  - IntVector never takes the value N_IRQ+1.

Decomposition:
- Package mc_pkg: state enum, opcode/funct constants, ALU code constants, PCSource/ALUSrcB encodings.
- One sub-module, mc_irq_arbiter: edge detect, pending bits, priority select, ack generation.
- The FSM and ALU decode stay in mc_controller_irq.

Test Plan:
- Reset during MEMWB of lw → next cycle state PREFETCH, RegWrite=0, all outputs 0.
- R-type Funct=100010 → EXEC drives ALUControl=3, RWB pulses RegWrite with RegDst=1; total 5 cycles.
- beq with Zero=0, then Zero=1 → PCWrite 0 then 1 in BRANCH, PCSource=01.
- IRQ=4'b0110 rising during an add, INTD=0 → at PREFETCH: INTR with IntVector=1, IntAck=0010, EPCWrite=1. Next instruction: INTR with IntVector=2.
- NMI and IRQ[0] rising together, INTD=1 → INTR with IntVector=4, NmiAck=1; pend[0] stays set until INTD=0, then IntVector=0.
- Op=111111 → with MC_TRAP_ILLEGAL_EN, IntVector=5 and EPCWrite=1; without it, 1 no-op cycle then PREFETCH.
